// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode table, flag bit positions and divider state encoding.
// FIXUP exists only in the signed build (ITERATIVE_DIVIDER_SIGNED_EN).
package alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'h00;
  localparam logic [5:0] ALU_SUB = 6'h01;
  localparam logic [5:0] ALU_AND = 6'h02;
  localparam logic [5:0] ALU_OR  = 6'h03;
  localparam logic [5:0] ALU_XOR = 6'h04;
  localparam logic [5:0] ALU_SHL = 6'h05;
  localparam logic [5:0] ALU_SHR = 6'h06;
  localparam logic [5:0] ALU_SAR = 6'h07;
  localparam logic [5:0] ALU_MUL = 6'h08;
  localparam logic [5:0] ALU_DIV = 6'h09;
  localparam logic [5:0] ALU_MOD = 6'h0A;
  localparam logic [5:0] ALU_CMP = 6'h0B;

  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 2;
  localparam int FLAG_OVERFLOW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
    FIXUP = 2'd3,
`endif
    DONE  = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Request/response channels between the execute stage and the iterative divider.
// signed_op is present only when ITERATIVE_DIVIDER_SIGNED_EN is defined.
interface iterative_divider_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  flags_in;
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
  logic        signed_op;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [7:0]  flags_out;

  modport master (
    output flush, in_valid, op, a, b, flags_in, out_ready,
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
    output signed_op,
`endif
    input  in_ready, out_valid, result, flags_out
  );

  modport slave (
    input  flush, in_valid, op, a, b, flags_in, out_ready,
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
    input  signed_op,
`endif
    output in_ready, out_valid, result, flags_out
  );
endinterface

// File: rtl/iterative_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);
  // The shifted remainder needs one extra bit so the compare never truncates.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_sub;
  logic           fits;

  assign rem_sh  = {rem, q[WIDTH-1]};
  assign fits    = rem_sh >= {1'b0, b};
  assign rem_sub = rem_sh - {1'b0, b};

  // The result of a restoring step is always below b, so the top bit drops cleanly.
  assign rem_next = fits ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], fits};
endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for ALU_DIV/ALU_MOD, one quotient bit per clock.
// Define ITERATIVE_DIVIDER_SIGNED_EN for signed operands (adds one FIXUP cycle).
module iterative_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  iterative_divider_if.slave bus
);
  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q, rem, dvs;
  logic [WIDTH-1:0] q_step, rem_step;
  logic [5:0]       op_r;
  logic [7:0]       flags_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [7:0]       flags_out_r;
  logic             accept;
  logic [WIDTH-1:0] a_load, b_load;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, ovf_c;

`ifdef ITERATIVE_DIVIDER_SIGNED_EN
  logic signed_r, neg_q_r, neg_r_r, ovf_r;
  // Magnitudes feed the unsigned core; signs are restored in FIXUP.
  assign a_load = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_load = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
`else
  assign a_load = bus.a;
  assign b_load = bus.b;
`endif

  assign accept        = bus.in_valid && (state == IDLE) && !bus.flush;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags_out = flags_out_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q        (q),
    .b        (dvs),
    .rem_next (rem_step),
    .q_next   (q_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (is_div_op(bus.op) && bus.b != '0) ? CALC : DONE;
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
      CALC:  if (cnt == '0) state_nxt = signed_r ? FIXUP : DONE;
      FIXUP: state_nxt = DONE;
`else
      CALC:  if (cnt == '0) state_nxt = DONE;
`endif
      DONE:  if (out_valid_r && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = flags_r[FLAG_OVERFLOW];
    if (!is_div_op(op_r)) begin
      res_c = '0;
    end else if (dvs == '0) begin
      res_c   = (op_r == ALU_DIV) ? '1 : '0;
      carry_c = 1'b1;
    end else begin
      res_c = (op_r == ALU_DIV) ? q : rem;
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
      ovf_c = flags_r[FLAG_OVERFLOW] | ovf_r;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      q           <= '0;
      rem         <= '0;
      dvs         <= '0;
      op_r        <= '0;
      flags_r     <= '0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      flags_out_r <= '0;
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
      signed_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      ovf_r       <= 1'b0;
`endif
    end else if (bus.flush) begin
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          q       <= a_load;
          rem     <= '0;
          dvs     <= b_load;
          op_r    <= bus.op;
          flags_r <= bus.flags_in;
          cnt     <= CNT_W'(WIDTH - 1);
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
          signed_r <= bus.signed_op;
          neg_q_r  <= bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_r_r  <= bus.signed_op && bus.a[WIDTH-1];
          ovf_r    <= bus.signed_op && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
`endif
        end
        CALC: begin
          q   <= q_step;
          rem <= rem_step;
          cnt <= cnt - 1'b1;
        end
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
        FIXUP: begin
          q   <= neg_q_r ? -q : q;
          rem <= neg_r_r ? -rem : rem;
        end
`endif
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            result_r    <= res_c;
            flags_out_r <= {flags_r[7:4], ovf_c, res_c[WIDTH-1], (res_c == '0), carry_c};
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
